// File: rtl/wisc_ctrl_pkg.sv
// Shared opcode constants and the per-instruction control bundle for the WISC
// control path, used by both the single-cycle and the pipelined builds.
package wisc_ctrl_pkg;

   localparam int OPC_LW  = 8;
   localparam int OPC_SW  = 9;
   localparam int OPC_B   = 12;
   localparam int OPC_BR  = 13;
   localparam int OPC_PCS = 14;
   localparam int OPC_HLT = 15;

   typedef struct packed {
      logic memread;
      logic memtoreg;
      logic memwrite;
      logic alusrc;
      logic regwrite;
      logic is_hlt;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipelined_control_unit_if.sv
// ID-stage inputs and per-stage control outputs exchanged between the datapath
// (master) and the pipelined control unit (slave).
interface pipelined_control_unit_if #(
   parameter int INSTR_W = 16,
   parameter int RADDR_W = 4
);
   logic               id_valid;
   logic [INSTR_W-1:0] id_instr;
   logic               ex_flush;
   logic               id_stall;
   logic               ex_alusrc;
   logic               ex_memread;
   logic [RADDR_W-1:0] ex_rd;
   logic               mem_memread;
   logic               mem_memwrite;
   logic               wb_regwrite;
   logic               wb_memtoreg;
   logic [RADDR_W-1:0] wb_rd;
   logic               halted;

   modport master (
      output id_valid, id_instr, ex_flush,
      input  id_stall, ex_alusrc, ex_memread, ex_rd, mem_memread, mem_memwrite,
             wb_regwrite, wb_memtoreg, wb_rd, halted
   );

   modport slave (
      input  id_valid, id_instr, ex_flush,
      output id_stall, ex_alusrc, ex_memread, ex_rd, mem_memread, mem_memwrite,
             wb_regwrite, wb_memtoreg, wb_rd, halted
   );
endinterface

// File: rtl/ctrl_decode.sv
// Pure combinational opcode decoder: control bundle plus which register source
// fields the instruction actually reads (for hazard detection).
module ctrl_decode
   import wisc_ctrl_pkg::*;
#(
   parameter int OPC_W = 4
) (
   input  logic [OPC_W-1:0] opc,
   input  logic             valid,
   output ctrl_t            ctrl,
   output logic             rs_used,
   output logic             rt_used
);

   always_comb begin
      ctrl    = CTRL_BUBBLE;
      rs_used = 1'b0;
      rt_used = 1'b0;
      if (valid) begin
         ctrl.memread  = (opc == OPC_W'(OPC_LW));
         ctrl.memtoreg = (opc == OPC_W'(OPC_LW));
         ctrl.memwrite = (opc == OPC_W'(OPC_SW));
         ctrl.alusrc   = opc inside {OPC_W'(4), OPC_W'(5), OPC_W'(6), OPC_W'(OPC_LW),
                                     OPC_W'(OPC_SW), OPC_W'(OPC_B), OPC_W'(OPC_BR),
                                     OPC_W'(OPC_PCS)};
         ctrl.regwrite = !(opc inside {OPC_W'(OPC_SW), OPC_W'(OPC_B), OPC_W'(OPC_BR),
                                       OPC_W'(OPC_HLT)});
         ctrl.is_hlt   = (opc == OPC_W'(OPC_HLT));
         // SW reads rt as its store data, so it counts as an rt consumer.
         rs_used = !(opc inside {OPC_W'(10), OPC_W'(11), OPC_W'(OPC_B), OPC_W'(OPC_PCS),
                                 OPC_W'(OPC_HLT)});
         rt_used = opc inside {OPC_W'(0), OPC_W'(1), OPC_W'(2), OPC_W'(3), OPC_W'(7),
                               OPC_W'(OPC_SW)};
      end
   end

endmodule

// File: rtl/pipelined_control_unit.sv
// Decodes the ID instruction, carries its control bits through ID/EX, EX/MEM and
// MEM/WB, and handles load-use interlock, branch flush and halt sequencing.
module pipelined_control_unit
   import wisc_ctrl_pkg::*;
#(
   parameter int INSTR_W        = 16,
   parameter int OPC_W          = 4,
   parameter int RADDR_W        = 4,
   parameter int LOAD_USE_STALL = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   pipelined_control_unit_if.slave bus
);

   typedef struct packed {
      ctrl_t              ctrl;
      logic [RADDR_W-1:0] rd;
      logic               valid;
   } stage_t;

   localparam stage_t STAGE_BUBBLE = '0;

   logic [OPC_W-1:0]   id_opc;
   logic [RADDR_W-1:0] id_rd;
   logic [RADDR_W-1:0] id_rs;
   logic [RADDR_W-1:0] id_rt;
   ctrl_t              id_ctrl;
   logic               id_rs_used;
   logic               id_rt_used;

   stage_t idex_reg, idex_next;
   stage_t exmem_reg;
   stage_t memwb_reg;
   logic   hlt_seen_reg, hlt_seen_next;
   logic   halted_reg, halted_next;
   logic   load_use;
   logic   stall;
   logic   wb_unused;

   assign id_opc = bus.id_instr[INSTR_W-1 -: OPC_W];
   assign id_rd  = bus.id_instr[3*RADDR_W-1 -: RADDR_W];
   assign id_rs  = bus.id_instr[2*RADDR_W-1 -: RADDR_W];
   assign id_rt  = bus.id_instr[RADDR_W-1:0];

   ctrl_decode #(
      .OPC_W(OPC_W)
   ) u_decode (
      .opc     (id_opc),
      .valid   (bus.id_valid),
      .ctrl    (id_ctrl),
      .rs_used (id_rs_used),
      .rt_used (id_rt_used)
   );

   // R0 is hardwired zero, so a load targeting it never creates a dependency.
   always_comb begin
      load_use = (LOAD_USE_STALL != 0) && bus.id_valid && idex_reg.valid
                 && idex_reg.ctrl.memread && (idex_reg.rd != '0)
                 && ((id_rs_used && (id_rs == idex_reg.rd))
                     || (id_rt_used && (id_rt == idex_reg.rd)));
      stall    = !rst && !bus.ex_flush && (load_use || hlt_seen_reg);
   end

   always_comb begin
      idex_next = STAGE_BUBBLE;
      if (!(rst || bus.ex_flush || stall || hlt_seen_reg || !bus.id_valid)) begin
         idex_next.ctrl  = id_ctrl;
         idex_next.rd    = id_rd;
         idex_next.valid = 1'b1;
      end
      hlt_seen_next = hlt_seen_reg || idex_next.ctrl.is_hlt;
      // The halt marker has retired once it is in MEM/WB at this edge.
      halted_next   = halted_reg || memwb_reg.ctrl.is_hlt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idex_reg     <= STAGE_BUBBLE;
         exmem_reg    <= STAGE_BUBBLE;
         memwb_reg    <= STAGE_BUBBLE;
         hlt_seen_reg <= 1'b0;
         halted_reg   <= 1'b0;
      end else begin
         idex_reg     <= idex_next;
         exmem_reg    <= idex_reg;
         memwb_reg    <= exmem_reg;
         hlt_seen_reg <= hlt_seen_next;
         halted_reg   <= halted_next;
      end
   end

   assign bus.id_stall     = stall;
   assign bus.ex_alusrc    = idex_reg.ctrl.alusrc;
   assign bus.ex_memread   = idex_reg.ctrl.memread;
   assign bus.ex_rd        = idex_reg.rd;
   assign bus.mem_memread  = exmem_reg.ctrl.memread;
   assign bus.mem_memwrite = exmem_reg.ctrl.memwrite;
   assign bus.wb_regwrite  = memwb_reg.ctrl.regwrite;
   assign bus.wb_memtoreg  = memwb_reg.ctrl.memtoreg;
   assign bus.wb_rd        = memwb_reg.rd;
   assign bus.halted       = halted_reg;

   // Control bits that have no consumer once the instruction reaches WB.
   assign wb_unused = ^{memwb_reg.ctrl.memread, memwb_reg.ctrl.memwrite,
                        memwb_reg.ctrl.alusrc, memwb_reg.valid};

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: a vector table for the streaming
// cases plus hand-written halt, reset and squashed-halt sequences.
module tb_pipelined_control_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [15:0] id_instr;
   logic        ex_flush;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   pipelined_control_unit_if #(.INSTR_W(16), .RADDR_W(4)) bus ();
   pipelined_control_unit_if #(.INSTR_W(16), .RADDR_W(4)) bus_nf ();

   assign bus.id_valid    = id_valid;
   assign bus.id_instr    = id_instr;
   assign bus.ex_flush    = ex_flush;
   assign bus_nf.id_valid = id_valid;
   assign bus_nf.id_instr = id_instr;
   assign bus_nf.ex_flush = ex_flush;

   pipelined_control_unit #(
      .INSTR_W(16), .OPC_W(4), .RADDR_W(4), .LOAD_USE_STALL(1)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   pipelined_control_unit #(
      .INSTR_W(16), .OPC_W(4), .RADDR_W(4), .LOAD_USE_STALL(0)
   ) u_dut_nf (
      .clk (clk),
      .rst (rst),
      .bus (bus_nf)
   );

   // {stall, ex_alusrc, ex_memread, ex_rd, mem_memread, mem_memwrite,
   //  wb_regwrite, wb_memtoreg, wb_rd, halted}
   logic [15:0] out_vec;
   assign out_vec = {bus.id_stall, bus.ex_alusrc, bus.ex_memread, bus.ex_rd,
                     bus.mem_memread, bus.mem_memwrite, bus.wb_regwrite,
                     bus.wb_memtoreg, bus.wb_rd, bus.halted};

   typedef struct {
      logic        valid;
      logic [15:0] instr;
      logic        flush;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl[19];

   function automatic logic [15:0] o(input logic st, input logic al, input logic mr,
                                     input logic [3:0] exrd, input logic mmr,
                                     input logic mmw, input logic rw, input logic m2r,
                                     input logic [3:0] wbrd, input logic h);
      return {st, al, mr, exrd, mmr, mmw, rw, m2r, wbrd, h};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic step(input logic v, input logic [15:0] ins, input logic fl);
      @(negedge clk);
      id_valid = v;
      id_instr = ins;
      ex_flush = fl;
      #1;
   endtask

   initial begin
      //                 valid instr    flush  st al mr exrd  mmr mmw rw m2r wbrd h
      tbl[0]  = '{1'b1, 16'h1123, 1'b0, o(0, 0, 0, 4'd0, 0, 0, 0, 0, 4'd0, 0)};
      tbl[1]  = '{1'b1, 16'h8400, 1'b0, o(0, 0, 0, 4'd1, 0, 0, 0, 0, 4'd0, 0)};
      tbl[2]  = '{1'b1, 16'h1546, 1'b0, o(1, 1, 1, 4'd4, 0, 0, 0, 0, 4'd0, 0)};
      tbl[3]  = '{1'b1, 16'h1546, 1'b0, o(0, 0, 0, 4'd0, 1, 0, 1, 0, 4'd1, 0)};
      tbl[4]  = '{1'b1, 16'h9102, 1'b0, o(0, 0, 0, 4'd5, 0, 0, 1, 1, 4'd4, 0)};
      tbl[5]  = '{1'b0, 16'h0000, 1'b0, o(0, 1, 0, 4'd1, 0, 0, 0, 0, 4'd0, 0)};
      tbl[6]  = '{1'b0, 16'h0000, 1'b0, o(0, 0, 0, 4'd0, 0, 1, 1, 0, 4'd5, 0)};
      tbl[7]  = '{1'b0, 16'h0000, 1'b0, o(0, 0, 0, 4'd0, 0, 0, 0, 0, 4'd1, 0)};
      tbl[8]  = '{1'b1, 16'h8000, 1'b0, o(0, 0, 0, 4'd0, 0, 0, 0, 0, 4'd0, 0)};
      tbl[9]  = '{1'b1, 16'h1203, 1'b0, o(0, 1, 1, 4'd0, 0, 0, 0, 0, 4'd0, 0)};
      tbl[10] = '{1'b0, 16'h0000, 1'b0, o(0, 0, 0, 4'd2, 1, 0, 0, 0, 4'd0, 0)};
      tbl[11] = '{1'b0, 16'h0000, 1'b0, o(0, 0, 0, 4'd0, 0, 0, 1, 1, 4'd0, 0)};
      tbl[12] = '{1'b0, 16'h0000, 1'b0, o(0, 0, 0, 4'd0, 0, 0, 1, 0, 4'd2, 0)};
      tbl[13] = '{1'b1, 16'h8700, 1'b0, o(0, 0, 0, 4'd0, 0, 0, 0, 0, 4'd0, 0)};
      tbl[14] = '{1'b1, 16'h1573, 1'b1, o(0, 1, 1, 4'd7, 0, 0, 0, 0, 4'd0, 0)};
      tbl[15] = '{1'b1, 16'h1234, 1'b0, o(0, 0, 0, 4'd0, 1, 0, 0, 0, 4'd0, 0)};
      tbl[16] = '{1'b0, 16'h0000, 1'b0, o(0, 0, 0, 4'd2, 0, 0, 1, 1, 4'd7, 0)};
      tbl[17] = '{1'b0, 16'h0000, 1'b0, o(0, 0, 0, 4'd0, 0, 0, 0, 0, 4'd0, 0)};
      tbl[18] = '{1'b0, 16'h0000, 1'b0, o(0, 0, 0, 4'd0, 0, 0, 1, 0, 4'd2, 0)};

      rst      = 1'b1;
      id_valid = 1'b1;
      id_instr = 16'h8400;
      ex_flush = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("reset_outputs", out_vec, 16'h0000);
      check("reset_nf_stall", {15'b0, bus_nf.id_stall}, 16'h0000);
      rst      = 1'b0;
      id_valid = 1'b0;

      for (int i = 0; i < 19; i++) begin
         step(tbl[i].valid, tbl[i].instr, tbl[i].flush);
         check($sformatf("vec%0d", i), out_vec, tbl[i].exp);
         check($sformatf("vec%0d_nointerlock_stall", i), {15'b0, bus_nf.id_stall}, 16'h0000);
      end

      // HLT followed by ADDs: ADDs must never write back, halted rises 3 cycles after EX entry.
      step(1'b1, 16'hF000, 1'b0);
      check("hlt_h0_stall", {15'b0, bus.id_stall}, 16'h0000);
      step(1'b1, 16'h1123, 1'b0);
      check("hlt_h1_stall_rw_halt", {13'b0, bus.id_stall, bus.wb_regwrite, bus.halted}, 16'b100);
      step(1'b1, 16'h1456, 1'b0);
      check("hlt_h2_stall_rw_halt", {13'b0, bus.id_stall, bus.wb_regwrite, bus.halted}, 16'b100);
      step(1'b1, 16'h1456, 1'b0);
      check("hlt_h3_stall_rw_halt", {13'b0, bus.id_stall, bus.wb_regwrite, bus.halted}, 16'b100);
      for (int k = 4; k < 8; k++) begin
         step(1'b1, 16'h1123, 1'b0);
         check($sformatf("hlt_h%0d_stall_rw_halt", k),
               {13'b0, bus.id_stall, bus.wb_regwrite, bus.halted}, 16'b101);
      end

      @(negedge clk);
      rst      = 1'b1;
      id_valid = 1'b1;
      id_instr = 16'h1123;
      @(negedge clk);
      #1;
      check("rst_clears_halt", out_vec, 16'h0000);
      rst      = 1'b0;
      id_valid = 1'b0;

      // HLT killed by a flush must not halt the machine.
      step(1'b1, 16'hF000, 1'b1);
      check("sq_x0_stall", {15'b0, bus.id_stall}, 16'h0000);
      step(1'b1, 16'h1123, 1'b0);
      check("sq_x1_stall_halt", {14'b0, bus.id_stall, bus.halted}, 16'h0000);
      step(1'b0, 16'h0000, 1'b0);
      step(1'b0, 16'h0000, 1'b0);
      step(1'b0, 16'h0000, 1'b0);
      check("sq_x4_wb", {9'b0, bus.wb_regwrite, bus.wb_rd, bus.halted, bus.id_stall},
            16'b1_0001_0_0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Parametrised successor of the single-cycle control decoder. Decodes the ID-stage instruction into the control bundle (memread, memtoreg, memwrite, alusrc, regwrite) and carries it through ID/EX, EX/MEM and MEM/WB control registers. Detects load-use hazards, applies branch flush and halt sequencing. Sits beside the datapath pipeline registers and drives every stage's control inputs.

Parameters:
INSTR_W, 16, instruction width
OPC_W, 4, opcode width; opcode = instr[INSTR_W-1 -: OPC_W]
RADDR_W, 4, register index width; rd = instr[3*RADDR_W-1 -: RADDR_W], rs = next field down, rt = lowest field
LOAD_USE_STALL, 1, 1 = internal load-use interlock enabled; 0 = id_stall tied low (forwarding handles it)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  instr holds a real instruction this cycle
id_instr  in  INSTR_W  instruction in ID
ex_flush  in  1  branch taken in EX; kill the ID-stage instruction
id_stall  out  1  hold PC and IF/ID this cycle
ex_alusrc  out  1  ALU B operand = immediate
ex_memread  out  1  EX-stage instruction is LW
ex_rd  out  RADDR_W  EX-stage destination
mem_memread  out  1  MEM-stage data-memory read enable
mem_memwrite  out  1  MEM-stage data-memory write enable
wb_regwrite  out  1  register-file write enable
wb_memtoreg  out  1  write-back selects memory data
wb_rd  out  RADDR_W  write-back destination
halted  out  1  sticky; HLT has retired

Behaviour:
- Decode (combinational, ID): memread = opc 8; memtoreg = memread; memwrite = opc 9; alusrc = opc in {4,5,6,8,9,C,D,E}; regwrite = opc not in {9,C,D,F}; is_hlt = opc F. All bits qualified by id_valid.
- Source use: rs used by every opcode except A, B, C, E, F; rt used only by opcodes 0-3, 7, 9 (SW reads rt as store data).
- Load-use: id_stall = LOAD_USE_STALL & id_valid & ex_valid & ex_memread & ((rs used & rs==ex_rd) | (rt used & rt==ex_rd)). No check when ex_rd is 0: R0 is hardwired zero.
- Each rising edge: ID/EX <= bubble if (rst | ex_flush | id_stall | hlt_seen | ~id_valid), else decoded bundle + rd + valid. EX/MEM <= ID/EX; MEM/WB <= EX/MEM, all unconditional (no back-pressure downstream).
- Bubble = all control bits 0, rd 0, valid 0.
- Priority: rst > ex_flush > id_stall. A flush during a stall cycle still inserts exactly one bubble; id_stall is forced 0 when ex_flush is 1.
- Latency: decode to ex_* 1 cycle, mem_* 2 cycles, wb_* 3 cycles.
- Halt: hlt_seen sets on the edge where an unflushed, unstalled HLT enters ID/EX. Afterwards all ID instructions become bubbles and id_stall stays 1. halted sets when the HLT marker leaves MEM/WB (3 cycles after entry). Both are sticky until rst.
- HLT squashed by ex_flush never sets hlt_seen.
- Reset: every stage register becomes a bubble; all outputs 0, including halted and id_stall. Reset mid-operation discards in-flight instructions with no partial writes on the reset edge.

Decomposition:
- Package wisc_ctrl_pkg: opcode localparams (OPC_LW=8, OPC_SW=9, OPC_B=C, OPC_BR=D, OPC_PCS=E, OPC_HLT=F), packed ctrl_t struct {memread, memtoreg, memwrite, alusrc, regwrite, is_hlt}, CTRL_BUBBLE constant.
- Sub-module ctrl_decode: pure combinational opcode-to-ctrl_t plus rs/rt-used flags, reused by the single-cycle build. Stage registers and the hazard unit stay in the top module.

Test Plan:
- Reset, then stream ADD r1,r2,r3 (0x1123): wb_regwrite=1, wb_memtoreg=0, wb_rd=1 exactly 3 cycles after issue; all outputs 0 during rst.
- LW r4 (0x84xx) followed by ADD r5,r4,r6: id_stall=1 for exactly one cycle, one bubble visible at ex_*, then the ADD proceeds. Repeat with LOAD_USE_STALL=0: no stall.
- LW r0 followed by ADD using r0: no stall.
- SW r2 issued: mem_memwrite=1 2 cycles later; wb_regwrite=0 the following cycle.
- Instruction in ID with ex_flush=1 coincident with a load-use stall: id_stall=0, one bubble inserted, the next instruction issues normally.
- HLT then two ADDs: the ADDs produce no wb_regwrite; halted rises 3 cycles after HLT enters EX and stays 1. Asserting rst clears halted and id_stall on the next edge.
